// File: rtl/quadrant_restorer.sv
// quadrant_restorer: maps first-quadrant CORDIC sin/cos back to the full angle using an in-order FIFO of quadrant tags
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
module quadrant_restorer #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en_restorer,
  input  logic                   quad_valid,
  input  logic [1:0]             quadrant,
  input  logic                   res_valid,
  input  logic [`DATA_WIDTH-1:0] sin_in,
  input  logic [`DATA_WIDTH-1:0] cos_in,
  output logic                   out_valid,
  output logic [`DATA_WIDTH-1:0] sin_out,
  output logic [`DATA_WIDTH-1:0] cos_out,
  output logic                   quad_full,
  output logic                   quad_empty,
  output logic                   err_overflow,
  output logic                   err_underflow
);
  localparam int W  = `DATA_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nx;
  logic          push_req, pop_req, is_full, is_empty, do_push, do_pop;
  logic [1:0]    head;
  logic [W-1:0]  neg_s, neg_c, sin_nx, cos_nx;
  // A pop needs a queued tag; a push into a full FIFO only fits when a pop frees a slot the same cycle
  always_comb begin
    push_req = en_restorer & quad_valid;
    pop_req  = en_restorer & res_valid;
    is_full  = count == CW'(DEPTH);
    is_empty = count == '0;
    do_pop   = pop_req & ~is_empty;
    do_push  = push_req & (~is_full | do_pop);
    count_nx = count + CW'(do_push) - CW'(do_pop);
    head     = mem[rd_ptr];
  end
  // Quadrant restore is pure swap and sign-bit flip; zero becomes -0 on purpose
  always_comb begin
    neg_s  = {~sin_in[W-1], sin_in[W-2:0]};
    neg_c  = {~cos_in[W-1], cos_in[W-2:0]};
    sin_nx = head == 2'd0 ? sin_in : head == 2'd1 ? cos_in : head == 2'd2 ? neg_s : neg_c;
    cos_nx = head == 2'd0 ? cos_in : head == 2'd1 ? neg_s  : head == 2'd2 ? neg_c : sin_in;
  end
  // Tag storage needs no reset; only pointers and count define validity
  always_ff @(posedge clk)
    if (reset_n && do_push) mem[wr_ptr] <= quadrant;
  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count_nx;
    end
  // Registered status, sticky errors and result outputs that hold between pops
  always_ff @(posedge clk)
    if (!reset_n) begin
      out_valid     <= 1'b0;
      sin_out       <= '0;
      cos_out       <= '0;
      quad_full     <= 1'b0;
      quad_empty    <= 1'b1;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      out_valid     <= do_pop;
      sin_out       <= do_pop ? sin_nx : sin_out;
      cos_out       <= do_pop ? cos_nx : cos_out;
      quad_full     <= count_nx == CW'(DEPTH);
      quad_empty    <= count_nx == '0;
      err_overflow  <= err_overflow | (push_req & is_full & ~pop_req);
      err_underflow <= err_underflow | (pop_req & is_empty);
    end
endmodule

// File: tb/tb_quadrant_restorer.sv
// tb_quadrant_restorer: directed vector table plus a pointer-wrap sequence for quadrant_restorer
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
module tb_quadrant_restorer;
  localparam int W = `DATA_WIDTH;
  localparam logic [W-1:0] A  = 64'h3FEBB67AE8584CAA;
  localparam logic [W-1:0] H  = 64'h3FE0000000000000;
  localparam logic [W-1:0] NA = 64'hBFEBB67AE8584CAA;
  localparam logic [W-1:0] NH = 64'hBFE0000000000000;
  localparam logic [W-1:0] Z  = 64'h0;
  localparam logic [W-1:0] NZ = 64'h8000000000000000;
  typedef struct packed {
    logic rn, en, qv;
    logic [1:0] q;
    logic rv;
    logic [W-1:0] s, c;
    logic ov;
    logic [W-1:0] so, co;
    logic fu, em, eo, eu;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n, en_restorer, quad_valid, res_valid;
  logic [1:0] quadrant;
  logic [W-1:0] sin_in, cos_in, sin_out, cos_out;
  logic out_valid, quad_full, quad_empty, err_overflow, err_underflow;
  int vectors = 0;
  int miscompares = 0;
  vec_t tbl [34];
  always #5 clk = ~clk;
  quadrant_restorer #(.DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .en_restorer(en_restorer), .quad_valid(quad_valid),
    .quadrant(quadrant), .res_valid(res_valid), .sin_in(sin_in), .cos_in(cos_in),
    .out_valid(out_valid), .sin_out(sin_out), .cos_out(cos_out), .quad_full(quad_full),
    .quad_empty(quad_empty), .err_overflow(err_overflow), .err_underflow(err_underflow)
  );
  function automatic vec_t mk(logic rn, logic en, logic qv, logic [1:0] q, logic rv,
                              logic [W-1:0] s, logic [W-1:0] c, logic ov, logic [W-1:0] so,
                              logic [W-1:0] co, logic fu, logic em, logic eo, logic eu);
    return {rn, en, qv, q, rv, s, c, ov, so, co, fu, em, eo, eu};
  endfunction
  // reference mapping for inputs s=H, c=A, used by the wrap sequence
  function automatic logic [2*W-1:0] ref_hA(int q);
    case (q)
      0: return {H, A};
      1: return {A, NH};
      2: return {NH, NA};
      default: return {NA, H};
    endcase
  endfunction
  task automatic apply(input vec_t v, input string name);
    logic [2*W+4:0] got, exp;
    reset_n = v.rn; en_restorer = v.en; quad_valid = v.qv; quadrant = v.q;
    res_valid = v.rv; sin_in = v.s; cos_in = v.c;
    @(posedge clk);
    #1;
    got = {out_valid, sin_out, cos_out, quad_full, quad_empty, err_overflow, err_underflow};
    exp = {v.ov, v.so, v.co, v.fu, v.em, v.eo, v.eu};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got ov=%b so=%h co=%h full=%b empty=%b eo=%b eu=%b, exp ov=%b so=%h co=%h full=%b empty=%b eo=%b eu=%b",
               name, out_valid, sin_out, cos_out, quad_full, quad_empty, err_overflow, err_underflow,
               v.ov, v.so, v.co, v.fu, v.em, v.eo, v.eu);
    end
  endtask
  initial begin
    //            rn en qv q  rv s  c   ov so  co  fu em eo eu
    tbl[0]  = mk(0, 1, 0, 0, 0, Z, Z,  0, Z,  Z,  0, 1, 0, 0);
    tbl[1]  = mk(1, 1, 1, 1, 0, Z, Z,  0, Z,  Z,  0, 0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 0, 1, A, H,  1, H,  NA, 0, 1, 0, 0);
    tbl[3]  = mk(1, 1, 0, 0, 0, Z, Z,  0, H,  NA, 0, 1, 0, 0);
    tbl[4]  = mk(1, 1, 1, 0, 0, Z, Z,  0, H,  NA, 0, 0, 0, 0);
    tbl[5]  = mk(1, 1, 1, 1, 0, Z, Z,  0, H,  NA, 0, 0, 0, 0);
    tbl[6]  = mk(1, 1, 1, 2, 0, Z, Z,  0, H,  NA, 0, 0, 0, 0);
    tbl[7]  = mk(1, 1, 1, 3, 0, Z, Z,  0, H,  NA, 1, 0, 0, 0);
    tbl[8]  = mk(1, 1, 0, 0, 1, H, A,  1, H,  A,  0, 0, 0, 0);
    tbl[9]  = mk(1, 1, 0, 0, 1, H, A,  1, A,  NH, 0, 0, 0, 0);
    tbl[10] = mk(1, 1, 0, 0, 1, H, A,  1, NH, NA, 0, 0, 0, 0);
    tbl[11] = mk(1, 1, 0, 0, 1, H, A,  1, NA, H,  0, 1, 0, 0);
    tbl[12] = mk(1, 1, 0, 0, 0, Z, Z,  0, NA, H,  0, 1, 0, 0);
    tbl[13] = mk(1, 1, 1, 2, 0, Z, Z,  0, NA, H,  0, 0, 0, 0);
    tbl[14] = mk(1, 1, 1, 3, 0, Z, Z,  0, NA, H,  0, 0, 0, 0);
    tbl[15] = mk(1, 1, 1, 0, 0, Z, Z,  0, NA, H,  0, 0, 0, 0);
    tbl[16] = mk(1, 1, 1, 1, 0, Z, Z,  0, NA, H,  1, 0, 0, 0);
    tbl[17] = mk(1, 1, 1, 2, 0, Z, Z,  0, NA, H,  1, 0, 1, 0);
    tbl[18] = mk(1, 1, 1, 3, 1, H, A,  1, NH, NA, 1, 0, 1, 0);
    tbl[19] = mk(1, 0, 1, 0, 1, A, A,  0, NH, NA, 1, 0, 1, 0);
    tbl[20] = mk(1, 1, 0, 0, 1, H, A,  1, NA, H,  0, 0, 1, 0);
    tbl[21] = mk(1, 1, 0, 0, 1, H, A,  1, H,  A,  0, 0, 1, 0);
    tbl[22] = mk(1, 1, 0, 0, 1, H, A,  1, A,  NH, 0, 0, 1, 0);
    tbl[23] = mk(1, 1, 0, 0, 1, H, A,  1, NA, H,  0, 1, 1, 0);
    tbl[24] = mk(1, 1, 1, 2, 1, H, A,  0, NA, H,  0, 0, 1, 1);
    tbl[25] = mk(1, 1, 0, 0, 1, Z, Z,  1, NZ, NZ, 0, 1, 1, 1);
    tbl[26] = mk(1, 1, 1, 1, 0, Z, Z,  0, NZ, NZ, 0, 0, 1, 1);
    tbl[27] = mk(1, 1, 1, 1, 0, Z, Z,  0, NZ, NZ, 0, 0, 1, 1);
    tbl[28] = mk(1, 1, 1, 1, 0, Z, Z,  0, NZ, NZ, 0, 0, 1, 1);
    tbl[29] = mk(0, 1, 1, 2, 1, H, A,  0, Z,  Z,  0, 1, 0, 0);
    tbl[30] = mk(1, 1, 0, 0, 1, H, A,  0, Z,  Z,  0, 1, 0, 1);
    tbl[31] = mk(1, 0, 1, 1, 1, H, A,  0, Z,  Z,  0, 1, 0, 1);
    tbl[32] = mk(1, 1, 1, 3, 0, Z, Z,  0, Z,  Z,  0, 0, 0, 1);
    tbl[33] = mk(1, 1, 0, 0, 1, H, A,  1, NA, H,  0, 1, 0, 1);
    for (int i = 0; i < 34; i++) apply(tbl[i], $sformatf("vec%0d", i));
    // single-entry streaming: push and pop every cycle so both pointers wrap twice
    apply(mk(1, 1, 1, 0, 0, Z, Z, 0, NA, H, 0, 0, 0, 1), "wrap_fill");
    for (int i = 1; i < 10; i++) begin
      logic [2*W-1:0] r;
      r = ref_hA((i - 1) % 4);
      apply(mk(1, 1, 1, 2'(i % 4), 1, H, A, 1, r[2*W-1:W], r[W-1:0], 0, 0, 0, 1),
            $sformatf("wrap%0d", i));
    end
    apply(mk(1, 1, 0, 0, 1, H, A, 1, A, NH, 0, 1, 0, 1), "wrap_drain");
    apply(mk(1, 1, 0, 0, 0, Z, Z, 0, A, NH, 0, 1, 0, 1), "wrap_idle");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
